// File: rtl/addr_seq_if.sv
// Handshake/bus bundle for addr_seq_counter: window control in, address and status out.
// Passes is present only when ADDR_SEQ_PASSES_EN is defined.
interface addr_seq_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
);
    logic                  Start;
    logic                  Inc;
    logic [ADDR_WIDTH-1:0] Base;
    logic [ADDR_WIDTH-1:0] Limit;
    logic [ADDR_WIDTH-1:0] Addr;
    logic                  Busy;
    logic                  Last;
    logic                  Done;

    if (ADDR_WIDTH < 1 || CNT_WIDTH < 1) begin : gBadWidth
        $error("addr_seq_if: ADDR_WIDTH and CNT_WIDTH must be at least 1");
    end

`ifdef ADDR_SEQ_PASSES_EN
    logic [CNT_WIDTH-1:0]  Passes;

    modport master (output Start, Inc, Base, Limit, input Addr, Busy, Last, Done, Passes);
    modport slave  (input Start, Inc, Base, Limit, output Addr, Busy, Last, Done, Passes);
`else
    modport master (output Start, Inc, Base, Limit, input Addr, Busy, Last, Done);
    modport slave  (input Start, Inc, Base, Limit, output Addr, Busy, Last, Done);
`endif
endinterface

// File: rtl/addr_seq_counter.sv
// Bounded-window address sequencer: Start loads Base/Limit, Inc advances by STEP,
// one-shot (Done pulse) or ring (reload Base) at the limit. Optional pass counter: ADDR_SEQ_PASSES_EN.
//
// state | meaning
// IDLE  | no window active, Addr holds its last value
// RUN   | window active, Inc advances Addr
// DONE  | one-shot window just completed, Done high for this cycle
module addr_seq_counter #(
    parameter int ADDR_WIDTH = 3,
    parameter int STEP       = 1,
    parameter int WRAP       = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic       clock,
    input  logic       Reset,
    addr_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState;

    localparam logic [ADDR_WIDTH-1:0] STEP_INC = ADDR_WIDTH'(STEP);

    if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : gBadStep
        $error("addr_seq_counter: STEP must be 1, 2 or 4");
    end
    if (CNT_WIDTH < 1) begin : gBadCnt
        $error("addr_seq_counter: CNT_WIDTH must be at least 1");
    end

    seqState               state;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [ADDR_WIDTH-1:0] baseQ;
    logic [ADDR_WIDTH-1:0] limitQ;
    logic                  busyQ;
    logic                  doneQ;
    logic                  atLimit;

    assign atLimit  = (addrQ == limitQ);
    assign bus.Addr = addrQ;
    assign bus.Busy = busyQ;
    assign bus.Done = doneQ;
    assign bus.Last = busyQ && atLimit;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            addrQ  <= '0;
            baseQ  <= '0;
            limitQ <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (bus.Start) begin
                // Start wins over Inc in every state, including a restart mid-window
                addrQ  <= bus.Base;
                baseQ  <= bus.Base;
                limitQ <= bus.Limit;
                state  <= RUN;
                busyQ  <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.Inc) begin
                            if (!atLimit) begin
                                addrQ <= addrQ + STEP_INC;
                            end else if (WRAP != 0) begin
                                addrQ <= baseQ;
                            end else begin
                                state <= DONE;
                                busyQ <= 1'b0;
                                doneQ <= 1'b1;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef ADDR_SEQ_PASSES_EN
    logic [CNT_WIDTH-1:0] passesQ;
    logic                 windowEnd;

    // A window completes on the final Inc at the limit, whether that ends the run or reloads Base
    assign windowEnd  = busyQ && bus.Inc && !bus.Start && atLimit;
    assign bus.Passes = passesQ;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            passesQ <= '0;
        end else if (windowEnd && !(&passesQ)) begin
            passesQ <= passesQ + 1'b1;
        end
    end
`endif
endmodule

// File: doc/addr_seq_counter.md
Name: addr_seq_counter

Overview:
- Parametrised address sequencer for memory-to-memory transfer datapaths. Generalises the fixed 3-bit, zero-based incrementing address counter.
- Runs a bounded address window: Start loads a programmable base, Inc advances by STEP, and the block detects the programmed limit.
- At the limit it either stops with a Done pulse or wraps back to base (ring-buffer mode). One instance per memory port (source A, destination B).

Parameters:
- ADDR_WIDTH, 3, width of Addr, Base, Limit.
- STEP, 1, increment per Inc; legal values 1, 2, 4; (Limit-Base) mod 2^ADDR_WIDTH must be a multiple of STEP.
- WRAP, 0, 0 = one-shot (stop at limit), 1 = ring (reload Base after limit).
- CNT_WIDTH, 8, width of Passes (optional feature only).

Ports:
- clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  load Base/Limit and begin a window
- Inc  input  1  advance address (ignored unless running)
- Base  input  ADDR_WIDTH  first address of window, sampled on Start
- Limit  input  ADDR_WIDTH  last address of window, sampled on Start
- Addr  output  ADDR_WIDTH  current address (registered)
- Busy  output  1  high in RUN state
- Last  output  1  combinational: Busy && Addr==limit_q
- Done  output  1  one-cycle pulse on window completion (one-shot mode)
- Passes  output  CNT_WIDTH  completed windows (only with ADDR_SEQ_PASSES_EN)

Behaviour:
- Reset (async, any time incl. mid-window): state=IDLE, Addr=0, base_q=0, limit_q=0, Busy=0, Done=0, Passes=0. Last=0 follows.
- States: IDLE, RUN, DONE.
- Start (any state, highest priority over Inc):
  - Next edge: Addr<=Base, base_q<=Base, limit_q<=Limit, state<=RUN, Done<=0.
  - Start in RUN restarts the window; the interrupted window does not count as complete.
- In RUN with Inc=1, Start=0:
  - Addr!=limit_q: Addr<=Addr+STEP, modulo 2^ADDR_WIDTH (window may straddle all-ones to zero when Base>Limit).
  - Addr==limit_q, WRAP=0: Addr holds, state<=DONE, Done=1 for exactly that following cycle.
  - Addr==limit_q, WRAP=1: Addr<=base_q, stay RUN, no Done pulse.
- RUN with Inc=0: hold everything.
- IDLE/DONE: Inc ignored, Addr holds last value.
- DONE → IDLE after one cycle unless Start that cycle, in which case DONE → RUN.
- Base==Limit: single-address window. The first Inc completes it (one-shot) or reloads the same address (ring).
- Latency:
  - Addr valid the cycle after the Start/Inc edge.
  - Last is combinational from registered state; no input-to-output combinational path.
- Base/Limit changes outside a Start cycle have no effect.

Optional Feature:
- Macro ADDR_SEQ_PASSES_EN.
- Defined:
  - Passes increments by 1 on each completed window: the Done event (WRAP=0) or the limit→base reload (WRAP=1).
  - Saturates at all-ones.
  - Cleared by Reset only; Start does not clear it.
- Undefined: Passes port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN with Addr=5 → Addr=0, Busy=0, Done=0 immediately (before next clock edge).
- Defaults, Base=2, Limit=5, Start, Inc held high → Addr 2,3,4,5. Last high at 5. Next edge: Done=1 for one cycle, Busy=0, Addr stays 5. Further Inc ignored.
- WRAP=1, Base=6, Limit=1, Inc continuous → Addr 6,7,0,1,6,7…, no Done, Busy stays 1. With ADDR_SEQ_PASSES_EN: Passes 0→1 on the first 1→6 reload, 2 on the second.
- STEP=2, ADDR_WIDTH=4, Base=4, Limit=10 → Addr 4,6,8,10. Done after the Inc at 10. Inc deasserted for 3 cycles mid-window → Addr holds.
- Start asserted together with Inc while RUN at Addr=3, Base=0 → next Addr=0 (Start wins), no Done, Passes unchanged.
- Base=Limit=7, Start then a single Inc → Last high while Addr=7, Done pulse on the following cycle, state returns to IDLE one cycle later.
